// File: rtl/ua_transmit_cfg_pkg.sv
// Shared definitions for the parametrised UART transmitter: FSM states,
// parity modes and a ceiling-log2 helper for counter widths.
package ua_transmit_cfg_pkg;

  typedef enum logic [2:0] {
    UA_TX_IDLE   = 3'd0,
    UA_TX_START  = 3'd1,
    UA_TX_DATA   = 3'd2,
    UA_TX_PARITY = 3'd3,
    UA_TX_STOP   = 3'd4
  } tx_state_e;

  localparam int unsigned UA_PAR_NONE = 0;
  localparam int unsigned UA_PAR_EVEN = 1;
  localparam int unsigned UA_PAR_ODD  = 2;

  // Bits needed to hold 0..value-1; never less than 1.
  function automatic int unsigned ua_log2(input int unsigned value);
    int unsigned width;
    width = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/ua_transmit_cfg_fifo.sv
// Synchronous FIFO feeding the UART transmitter; Depth must be a power of 2.
module ua_tx_fifo
  import ua_transmit_cfg_pkg::*;
#(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] push_data,
  output logic [Width-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = ua_log2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [PtrW:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PtrW+1)'(Depth));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge Clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ua_transmit_cfg.sv
// Parametrised UART transmitter (start, DataBits LSB-first, optional parity, stop bits).
// UATX_FIFO_EN selects a ua_tx_fifo input buffer; otherwise a single holding register.
module ua_transmit_cfg
  import ua_transmit_cfg_pkg::*;
#(
  parameter int unsigned ClockFreq  = 100_000_000,
  parameter int unsigned BaudRate   = 115_200,
  parameter int unsigned DataBits   = 8,
  parameter int unsigned ParityMode = 0,
  parameter int unsigned StopBits   = 1,
  parameter int unsigned FifoDepth  = 4
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic [DataBits-1:0] DataIn,
  input  logic                DataInValid,
  output logic                DataInReady,
  output logic                SOut,
  output logic                TxBusy,
  output logic                TxDone
);

  localparam int unsigned SymbolEdgeTime = ClockFreq / BaudRate;
  localparam int unsigned BaudW = ua_log2(SymbolEdgeTime);
  localparam int unsigned BitW  = ua_log2(DataBits);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(SymbolEdgeTime - 1);
  localparam logic [BitW-1:0]  DataLast = BitW'(DataBits - 1);
  localparam logic [BitW-1:0]  StopLast = BitW'(StopBits - 1);

  if (SymbolEdgeTime < 4 || DataBits < 5 || DataBits > 9 || ParityMode > 2 ||
      StopBits < 1 || StopBits > 2 || FifoDepth < 2 ||
      (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_cfg
    $error("ua_transmit_cfg: illegal parameter set");
  end

  tx_state_e           state, state_next;
  logic [BaudW-1:0]    baud_cnt;
  logic [BitW-1:0]     bit_cnt;
  logic [DataBits-1:0] shift_q;
  logic                parity_q;
  logic                parity_calc;
  logic                symbol_edge;
  logic                load;
  logic                push;
  logic                buf_avail;
  logic                buf_pending;
  logic [DataBits-1:0] buf_data;

  assign push        = DataInValid & DataInReady;
  assign symbol_edge = (baud_cnt == BaudLast);

`ifdef UATX_FIFO_EN
  logic fifo_full;
  logic fifo_empty;
  logic avail_q;

  ua_tx_fifo #(
    .Width (DataBits),
    .Depth (FifoDepth)
  ) u_fifo (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .push      (push),
    .pop       (load),
    .push_data (DataIn),
    .pop_data  (buf_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A fresh entry must have been resident a full cycle before the FSM may take it.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) avail_q <= 1'b0;
    else          avail_q <= ~fifo_empty;
  end

  assign DataInReady = ~fifo_full;
  assign buf_avail   = ~fifo_empty & avail_q;
  assign buf_pending = ~fifo_empty;
`else
  logic                hold_full;
  logic [DataBits-1:0] hold_q;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      hold_full <= 1'b0;
      hold_q    <= '0;
    end else if (push) begin
      hold_full <= 1'b1;
      hold_q    <= DataIn;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  assign DataInReady = ~hold_full;
  assign buf_avail   = hold_full;
  assign buf_pending = hold_full;
  assign buf_data    = hold_q;
`endif

  assign parity_calc = (ParityMode == UA_PAR_ODD) ? ~(^buf_data) : (^buf_data);

  always_comb begin
    state_next = state;
    load       = 1'b0;
    TxDone     = 1'b0;
    case (state)
      UA_TX_IDLE: begin
        if (buf_avail) begin
          load       = 1'b1;
          state_next = UA_TX_START;
        end
      end
      UA_TX_START: if (symbol_edge) state_next = UA_TX_DATA;
      UA_TX_DATA: begin
        if (symbol_edge && bit_cnt == DataLast)
          state_next = (ParityMode != UA_PAR_NONE) ? UA_TX_PARITY : UA_TX_STOP;
      end
      UA_TX_PARITY: if (symbol_edge) state_next = UA_TX_STOP;
      UA_TX_STOP: begin
        if (symbol_edge && bit_cnt == StopLast) begin
          TxDone = 1'b1;
          if (buf_avail) begin
            load       = 1'b1;
            state_next = UA_TX_START;
          end else begin
            state_next = UA_TX_IDLE;
          end
        end
      end
      default: state_next = UA_TX_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= UA_TX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
    end else begin
      state <= state_next;

      if (load || state == UA_TX_IDLE || symbol_edge) baud_cnt <= '0;
      else                                            baud_cnt <= baud_cnt + 1'b1;

      // Bit index restarts whenever the FSM moves to another field.
      if (load)             bit_cnt <= '0;
      else if (symbol_edge) bit_cnt <= (state_next != state) ? '0 : bit_cnt + 1'b1;

      if (load) begin
        shift_q  <= buf_data;
        parity_q <= parity_calc;
      end else if (state == UA_TX_DATA && symbol_edge) begin
        shift_q <= shift_q >> 1;
      end
    end
  end

  always_comb begin
    SOut = 1'b1;
    case (state)
      UA_TX_START:  SOut = 1'b0;
      UA_TX_DATA:   SOut = shift_q[0];
      UA_TX_PARITY: SOut = parity_q;
      default:      SOut = 1'b1;
    endcase
  end

  assign TxBusy = (state != UA_TX_IDLE) || buf_pending;

endmodule
